// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared definitions for the I2C register-access controller.
//   state_t      : sequencer states
//   WR_BYTES/RD_BYTES and their last-index forms : bytes per transaction
//   RW_WRITE/RW_READ : R/W bit appended to the 7-bit device address
//   byte_cmd_t / byte_cmd() : per-byte command presented to the byte engine
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_NEXT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   localparam int WR_BYTES = 3;
   localparam int RD_BYTES = 4;
   localparam logic [1:0] WR_LAST_IDX = 2'd2;
   localparam logic [1:0] RD_LAST_IDX = 2'd3;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef struct packed {
      logic [7:0] data;
      logic       w_rn;
      logic       first;
      logic       last;
      logic       ack_out;
   } byte_cmd_t;

   // Byte idx of a transaction. Write: addr+W, reg, data.
   // Read: addr+W, reg (ends the write phase), addr+R (repeated START), read byte.
   function automatic byte_cmd_t byte_cmd(input logic       wr,
                                          input logic [1:0] idx,
                                          input logic [6:0] dev,
                                          input logic [7:0] ra,
                                          input logic [7:0] wd);
      byte_cmd_t cmd;
      cmd.data    = 8'h00;
      cmd.w_rn    = 1'b1;
      cmd.first   = 1'b0;
      cmd.last    = 1'b0;
      cmd.ack_out = 1'b0;
      case (idx)
         2'd0: begin
            cmd.data  = {dev, RW_WRITE};
            cmd.first = 1'b1;
         end
         2'd1: begin
            cmd.data = ra;
            cmd.last = ~wr;
         end
         2'd2: begin
            if (wr) begin
               cmd.data = wd;
               cmd.last = 1'b1;
            end else begin
               cmd.data  = {dev, RW_READ};
               cmd.first = 1'b1;
            end
         end
         2'd3: begin
            // Master receives; ack_out=1 NACKs the single read byte before STOP.
            cmd.data    = 8'hFF;
            cmd.w_rn    = 1'b0;
            cmd.ack_out = 1'b1;
            cmd.last    = 1'b1;
         end
         default: begin
            cmd.data = 8'h00;
         end
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl -- sequences single-register I2C writes and reads through a
// byte-level I2C engine, with NACK reporting and a per-byte timeout.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   req, req_wr, dev_addr,
//   reg_addr, wdata, ready       : request side (accepted when req & ready)
//   resp_valid, rdata,
//   err_nack, err_timeout        : response side (valid with resp_valid pulse)
//   byte_start, byte_data,
//   byte_w_rn, byte_first,
//   byte_last, byte_ack_out      : command to the byte engine
//   byte_rdata, byte_ack_in,
//   byte_done                    : completion from the byte engine
module i2c_reg_ctrl
   import i2c_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       req_wr,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wdata,
   output logic       ready,
   output logic       resp_valid,
   output logic [7:0] rdata,
   output logic       err_nack,
   output logic       err_timeout,
   output logic       byte_start,
   output logic [7:0] byte_data,
   output logic       byte_w_rn,
   output logic       byte_first,
   output logic       byte_last,
   output logic       byte_ack_out,
   input  logic [7:0] byte_rdata,
   input  logic       byte_ack_in,
   input  logic       byte_done
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_r;
   logic [1:0]    idx_r;
   logic [TW-1:0] tcnt_r;
   logic          wr_r;
   logic [6:0]    dev_r;
   logic [7:0]    reg_r;
   logic [7:0]    wdata_r;

   byte_cmd_t     acc_cmd_s;
   byte_cmd_t     nxt_cmd_s;
   logic [1:0]    last_idx_s;
   logic [TW-1:0] tcnt_inc_s;

   // Next byte command and counter helpers
   always_comb begin
      acc_cmd_s  = byte_cmd(req_wr, 2'd0, dev_addr, reg_addr, wdata);
      nxt_cmd_s  = byte_cmd(wr_r, idx_r + 2'd1, dev_r, reg_r, wdata_r);
      tcnt_inc_s = tcnt_r + TW'(1);
      if (wr_r) begin
         last_idx_s = WR_LAST_IDX;
      end else begin
         last_idx_s = RD_LAST_IDX;
      end
   end

   // Transaction sequencer, timeout counter and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         idx_r        <= 2'd0;
         tcnt_r       <= '0;
         wr_r         <= 1'b0;
         dev_r        <= 7'd0;
         reg_r        <= 8'd0;
         wdata_r      <= 8'd0;
         ready        <= 1'b1;
         resp_valid   <= 1'b0;
         rdata        <= 8'h00;
         err_nack     <= 1'b0;
         err_timeout  <= 1'b0;
         byte_start   <= 1'b0;
         byte_data    <= 8'h00;
         byte_w_rn    <= 1'b1;
         byte_first   <= 1'b0;
         byte_last    <= 1'b0;
         byte_ack_out <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req && ready) begin
                  wr_r        <= req_wr;
                  dev_r       <= dev_addr;
                  reg_r       <= reg_addr;
                  wdata_r     <= wdata;
                  ready       <= 1'b0;
                  idx_r       <= 2'd0;
                  rdata       <= 8'h00;
                  err_nack    <= 1'b0;
                  err_timeout <= 1'b0;
                  // Command is loaded together with the start pulse so it is
                  // already stable on the cycle byte_start is seen.
                  {byte_data, byte_w_rn, byte_first, byte_last, byte_ack_out} <= acc_cmd_s;
                  byte_start  <= 1'b1;
                  state_r     <= ST_ISSUE;
               end else begin
                  ready <= 1'b1;
               end
            end
            ST_ISSUE: begin
               byte_start <= 1'b0;
               tcnt_r     <= '0;
               state_r    <= ST_WAIT;
            end
            ST_WAIT: begin
               // byte_done is checked first so it beats a coincident expiry.
               if (byte_done) begin
                  if (byte_w_rn) begin
                     if (byte_ack_in) begin
                        err_nack <= 1'b1;
                     end else begin
                        err_nack <= err_nack;
                     end
                  end else begin
                     rdata <= byte_rdata;
                  end
                  state_r <= ST_NEXT;
               end else if (tcnt_inc_s == TMO_LAST) begin
                  // Expiry lands resp_valid TIMEOUT_CYCLES after byte_start.
                  tcnt_r      <= tcnt_inc_s;
                  err_timeout <= 1'b1;
                  resp_valid  <= 1'b1;
                  state_r     <= ST_RESP;
               end else begin
                  tcnt_r <= tcnt_inc_s;
               end
            end
            ST_NEXT: begin
               if (idx_r != last_idx_s) begin
                  idx_r      <= idx_r + 2'd1;
                  {byte_data, byte_w_rn, byte_first, byte_last, byte_ack_out} <= nxt_cmd_s;
                  byte_start <= 1'b1;
                  state_r    <= ST_ISSUE;
               end else begin
                  resp_valid <= 1'b1;
                  state_r    <= ST_RESP;
               end
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               ready      <= 1'b1;
               state_r    <= ST_IDLE;
            end
            default: begin
               resp_valid <= 1'b0;
               byte_start <= 1'b0;
               ready      <= 1'b1;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl -- randomized self-checking bench for i2c_reg_ctrl with a
// behavioural byte-engine responder and an expected-byte-list model.
module tb_i2c_reg_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req;
   logic       req_wr;
   logic [6:0] dev_addr;
   logic [7:0] reg_addr;
   logic [7:0] wdata;
   logic       ready;
   logic       resp_valid;
   logic [7:0] rdata;
   logic       err_nack;
   logic       err_timeout;
   logic       byte_start;
   logic [7:0] byte_data;
   logic       byte_w_rn;
   logic       byte_first;
   logic       byte_last;
   logic       byte_ack_out;
   logic [7:0] byte_rdata;
   logic       byte_ack_in;
   logic       byte_done;

   i2c_reg_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
      .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
      .ready(ready), .resp_valid(resp_valid), .rdata(rdata),
      .err_nack(err_nack), .err_timeout(err_timeout),
      .byte_start(byte_start), .byte_data(byte_data), .byte_w_rn(byte_w_rn),
      .byte_first(byte_first), .byte_last(byte_last), .byte_ack_out(byte_ack_out),
      .byte_rdata(byte_rdata), .byte_ack_in(byte_ack_in), .byte_done(byte_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int miscmp = 0;

   // engine configuration and observation ({data, w_rn, first, last, ack_out})
   logic [11:0] obs_q[$];
   logic [11:0] exp_q[$];
   logic [3:0]  nack_mask = 4'h0;
   logic [7:0]  eng_rdata = 8'h00;
   int          stall_idx = -1;
   int          eng_dmin = 0;
   int          eng_dmax = 0;
   bit          eng_busy = 1'b0;

   int cyc = 0;
   int resp_cnt = 0;
   int last_start_cyc = 0;
   int last_resp_cyc = 0;

   // results of the last transaction
   bit         got_resp;
   logic [7:0] r_rdata;
   logic       r_nack;
   logic       r_tmo;
   logic       r_ready;
   logic       exp_nack;
   logic [7:0] exp_rdata;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (byte_start) last_start_cyc = cyc;
      if (resp_valid) begin
         resp_cnt = resp_cnt + 1;
         last_resp_cyc = cyc;
      end
   end

   // Byte engine model: record each command, answer after a random delay.
   initial begin : engine
      int idx;
      int d;
      byte_done = 1'b0;
      byte_ack_in = 1'b0;
      byte_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (byte_start && rst_n) begin
            idx = obs_q.size();
            obs_q.push_back({byte_data, byte_w_rn, byte_first, byte_last, byte_ack_out});
            if (idx != stall_idx) begin
               eng_busy = 1'b1;
               d = $urandom_range(eng_dmax, eng_dmin);
               repeat (d) @(negedge clk);
               @(negedge clk);
               byte_done = 1'b1;
               byte_ack_in = (idx < 4) ? nack_mask[idx] : 1'b0;
               byte_rdata = eng_rdata;
               @(negedge clk);
               byte_done = 1'b0;
               byte_ack_in = 1'b0;
               eng_busy = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: bytes a transaction must put on the engine, plus result.
   task automatic build_exp(input bit wr, input logic [6:0] dev,
                            input logic [7:0] ra, input logic [7:0] wd);
      logic [7:0] aw;
      logic [7:0] ar;
      aw = 8'(dev) * 8'd2;
      ar = aw + 8'd1;
      exp_q.delete();
      exp_q.push_back({aw, 1'b1, 1'b1, 1'b0, 1'b0});
      if (wr) begin
         exp_q.push_back({ra, 1'b1, 1'b0, 1'b0, 1'b0});
         exp_q.push_back({wd, 1'b1, 1'b0, 1'b1, 1'b0});
      end else begin
         exp_q.push_back({ra, 1'b1, 1'b0, 1'b1, 1'b0});
         exp_q.push_back({ar, 1'b1, 1'b1, 1'b0, 1'b0});
         exp_q.push_back({8'hFF, 1'b0, 1'b0, 1'b1, 1'b1});
      end
      exp_nack = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i][3] && nack_mask[i]) exp_nack = 1'b1;
      end
      exp_rdata = wr ? 8'h00 : eng_rdata;
   endtask

   // Drive one request and collect the response (no checking here).
   task automatic run_txn(input bit wr, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd);
      int n;
      obs_q.delete();
      build_exp(wr, dev, ra, wd);
      got_resp = 1'b0;
      r_rdata = 8'h00;
      r_nack = 1'b0;
      r_tmo = 1'b0;
      n = 0;
      while (!ready && n < 3000) begin @(negedge clk); n++; end
      req = 1'b1; req_wr = wr; dev_addr = dev; reg_addr = ra; wdata = wd;
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!resp_valid && n < 3000) begin @(negedge clk); n++; end
      if (resp_valid) begin
         got_resp = 1'b1;
         r_rdata = rdata;
         r_nack = err_nack;
         r_tmo = err_timeout;
      end
      @(negedge clk);
      r_ready = ready;
      n = 0;
      while (eng_busy && n < 100) begin @(negedge clk); n++; end
   endtask

   task automatic test_reset();
      vecs++;
      if ({ready, resp_valid, rdata, err_nack, err_timeout} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         miscmp++;
         $display("FAIL reset_resp: got rdy=%b rv=%b rd=%h nk=%b to=%b want 1 0 00 0 0",
                  ready, resp_valid, rdata, err_nack, err_timeout);
      end
      vecs++;
      if ({byte_start, byte_data, byte_w_rn, byte_first, byte_last, byte_ack_out} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         miscmp++;
         $display("FAIL reset_byte: got st=%b d=%h w=%b f=%b l=%b a=%b want 0 00 1 0 0 0",
                  byte_start, byte_data, byte_w_rn, byte_first, byte_last, byte_ack_out);
      end
   endtask

   task automatic test_write_basic();
      nack_mask = 4'h0; eng_dmin = 0; eng_dmax = 3;
      run_txn(1'b1, 7'h48, 8'h10, 8'hA5);
      vecs++;
      if (!got_resp) begin miscmp++; $display("FAIL wr_resp: no resp_valid within bound"); end
      vecs++;
      if (obs_q.size() != 3) begin miscmp++; $display("FAIL wr_count: got %0d bytes want 3", obs_q.size()); end
      for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
         vecs++;
         if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL wr_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      vecs++;
      if ({r_rdata, r_nack, r_tmo} !== {8'h00, 1'b0, 1'b0}) begin
         miscmp++; $display("FAIL wr_result: got rd=%h nk=%b to=%b want 00 0 0", r_rdata, r_nack, r_tmo);
      end
      vecs++;
      if (r_ready !== 1'b1) begin miscmp++; $display("FAIL wr_ready_after: got %b want 1", r_ready); end
   endtask

   task automatic test_read_basic();
      nack_mask = 4'h0; eng_dmin = 0; eng_dmax = 3; eng_rdata = 8'h5C;
      run_txn(1'b0, 7'h48, 8'h22, 8'h00);
      vecs++;
      if (obs_q.size() != 4) begin miscmp++; $display("FAIL rd_count: got %0d bytes want 4", obs_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         vecs++;
         if (obs_q[i] !== exp_q[i]) begin miscmp++; $display("FAIL rd_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      vecs++;
      if (!got_resp || r_rdata !== 8'h5C || r_nack !== 1'b0 || r_tmo !== 1'b0) begin
         miscmp++; $display("FAIL rd_result: got resp=%b rd=%h nk=%b to=%b want 1 5c 0 0", got_resp, r_rdata, r_nack, r_tmo);
      end
   endtask

   task automatic test_nack();
      nack_mask = 4'b0001; eng_dmin = 0; eng_dmax = 2;
      run_txn(1'b1, 7'h3A, 8'h07, 8'h11);
      vecs++;
      if (obs_q.size() != 3) begin miscmp++; $display("FAIL nack_count: got %0d bytes want 3", obs_q.size()); end
      vecs++;
      if (!got_resp || r_nack !== 1'b1 || r_tmo !== 1'b0) begin
         miscmp++; $display("FAIL nack_flag: got resp=%b nk=%b to=%b want 1 1 0", got_resp, r_nack, r_tmo);
      end
      // the next transaction must start with a clean error flag
      nack_mask = 4'h0;
      run_txn(1'b1, 7'h3A, 8'h08, 8'h12);
      vecs++;
      if (r_nack !== 1'b0) begin miscmp++; $display("FAIL nack_cleared: got %b want 0", r_nack); end
   endtask

   task automatic test_timeout();
      nack_mask = 4'h0; stall_idx = 0;
      run_txn(1'b1, 7'h20, 8'h30, 8'h40);
      stall_idx = -1;
      vecs++;
      if (!got_resp || r_tmo !== 1'b1 || r_nack !== 1'b0 || r_rdata !== 8'h00) begin
         miscmp++; $display("FAIL tmo_flag: got resp=%b to=%b nk=%b rd=%h want 1 1 0 00", got_resp, r_tmo, r_nack, r_rdata);
      end
      vecs++;
      if (obs_q.size() != 1) begin miscmp++; $display("FAIL tmo_bytes: got %0d bytes want 1", obs_q.size()); end
      vecs++;
      if (last_resp_cyc - last_start_cyc != 16) begin
         miscmp++; $display("FAIL tmo_latency: got %0d cycles want 16", last_resp_cyc - last_start_cyc);
      end
      // byte_done on the very cycle of expiry wins
      eng_dmin = 14; eng_dmax = 14;
      run_txn(1'b1, 7'h21, 8'h31, 8'h41);
      vecs++;
      if (!got_resp || r_tmo !== 1'b0 || obs_q.size() != 3) begin
         miscmp++; $display("FAIL tmo_coincide: got resp=%b to=%b bytes=%0d want 1 0 3", got_resp, r_tmo, obs_q.size());
      end
      // one cycle later the timeout fires first
      eng_dmin = 15; eng_dmax = 15;
      run_txn(1'b1, 7'h22, 8'h32, 8'h42);
      vecs++;
      if (!got_resp || r_tmo !== 1'b1 || obs_q.size() != 1) begin
         miscmp++; $display("FAIL tmo_late: got resp=%b to=%b bytes=%0d want 1 1 1", got_resp, r_tmo, obs_q.size());
      end
      eng_dmin = 0; eng_dmax = 0;
   endtask

   task automatic test_reset_mid();
      int n;
      int rc;
      obs_q.delete();
      stall_idx = 0;
      n = 0;
      while (!ready && n < 3000) begin @(negedge clk); n++; end
      rc = resp_cnt;
      req = 1'b1; req_wr = 1'b1; dev_addr = 7'h55; reg_addr = 8'h66; wdata = 8'h77;
      n = 0;
      while (obs_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      vecs++;
      if (obs_q.size() != 1 || ready !== 1'b0) begin
         miscmp++; $display("FAIL mid_accepts: got starts=%0d rdy=%b want 1 0", obs_q.size(), ready);
      end
      rst_n = 1'b0;
      #1;
      vecs++;
      if (ready !== 1'b1 || resp_valid !== 1'b0 || byte_start !== 1'b0 || byte_w_rn !== 1'b1) begin
         miscmp++; $display("FAIL mid_reset_out: got rdy=%b rv=%b st=%b w=%b want 1 0 0 1", ready, resp_valid, byte_start, byte_w_rn);
      end
      req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vecs++;
      if (resp_cnt != rc || ready !== 1'b1) begin
         miscmp++; $display("FAIL mid_no_resp: got resp pulses=%0d rdy=%b want 0 1", resp_cnt - rc, ready);
      end
      stall_idx = -1;
   endtask

   task automatic test_random();
      bit         wr;
      logic [6:0] dev;
      logic [7:0] ra;
      logic [7:0] wd;
      bit         ok;
      for (int t = 0; t < 24; t++) begin
         wr = 1'($urandom_range(1, 0));
         dev = 7'($urandom);
         ra = 8'($urandom);
         wd = 8'($urandom);
         eng_rdata = 8'($urandom);
         nack_mask = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0;
         eng_dmin = 0;
         eng_dmax = 6;
         run_txn(wr, dev, ra, wd);
         ok = (obs_q.size() == exp_q.size());
         for (int i = 0; ok && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) ok = 1'b0;
         end
         vecs++;
         if (!ok) begin
            miscmp++; $display("FAIL rand%0d_bytes: wr=%b got %0d bytes first=%h want %0d first=%h",
                               t, wr, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 12'h000, exp_q.size(), exp_q[0]);
         end
         vecs++;
         if (!got_resp || r_rdata !== exp_rdata || r_nack !== exp_nack || r_tmo !== 1'b0 || r_ready !== 1'b1) begin
            miscmp++; $display("FAIL rand%0d_result: got resp=%b rd=%h nk=%b to=%b rdy=%b want 1 %h %b 0 1",
                               t, got_resp, r_rdata, r_nack, r_tmo, r_ready, exp_rdata, exp_nack);
         end
      end
      nack_mask = 4'h0;
   endtask

   task automatic test_back_to_back();
      int c0;
      eng_dmin = 0; eng_dmax = 0; eng_rdata = 8'hC3;
      c0 = resp_cnt;
      run_txn(1'b0, 7'h11, 8'h01, 8'h00);
      run_txn(1'b1, 7'h12, 8'h02, 8'h9E);
      vecs++;
      if (resp_cnt - c0 != 2 || obs_q.size() != 3 || obs_q[2] !== exp_q[2]) begin
         miscmp++; $display("FAIL b2b: got resp=%0d bytes=%0d want 2 3", resp_cnt - c0, obs_q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req = 1'b0; req_wr = 1'b0; dev_addr = 7'h00; reg_addr = 8'h00; wdata = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_write_basic();
      test_read_basic();
      test_nack();
      test_timeout();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
